// File: rtl/histogram_pkg.sv
// Shared types for the histogram controller: the FSM state encoding and
// default-configuration constants.
package histogram_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_IN_RD   = 3'd2,
    S_IN_WAIT = 3'd3,
    S_SC_RD   = 3'd4,
    S_SC_WAIT = 3'd5,
    S_SC_WR   = 3'd6,
    S_FIN     = 3'd7
  } hist_state_t;

  localparam int PIXEL_W_DEF = 8;
  localparam int BIN_W_DEF   = 16;
  localparam int NUM_BINS    = 2 ** PIXEL_W_DEF;
  localparam logic [BIN_W_DEF-1:0] BIN_MAX = {BIN_W_DEF{1'b1}};

endpackage

// File: rtl/hist_latency_timer.sv
// Load/count-down timer covering one memory read latency; expire_o marks the
// last cycle of the wait, i.e. the cycle in which read data is valid.
module hist_latency_timer #(
  parameter int MEM_LAT = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load_i,
  output logic expire_o
);

  localparam int CW = $clog2(MEM_LAT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(MEM_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CW'(1));

endmodule

// File: rtl/histogram_engine_ctrl.sv
// Histogram controller: optional bin clear, then per pixel a read of the input
// memory followed by a saturating read-modify-write of the matching bin.
module histogram_engine_ctrl
  import histogram_pkg::*;
#(
  parameter int PIXEL_W  = 8,
  parameter int BIN_W    = 16,
  parameter int ADDR_W   = 12,
  parameter int MEM_LAT  = 3,
  parameter int CLEAR_EN = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  num_pixels,
  output logic               in_rd_en,
  output logic [ADDR_W-1:0]  in_rd_addr,
  input  logic [PIXEL_W-1:0] in_rd_data,
  output logic               sc_rd_en,
  output logic               sc_wr_en,
  output logic [PIXEL_W-1:0] sc_addr,
  input  logic [BIN_W-1:0]   sc_rd_data,
  output logic [BIN_W-1:0]   sc_wr_data,
  output logic               busy,
  output logic               done,
  output logic               saturated,
  output hist_state_t        dbg_state
);

  localparam logic [BIN_W-1:0] BIN_TOP = {BIN_W{1'b1}};

  hist_state_t        state_q, state_d;
  logic [ADDR_W-1:0]  num_q, num_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [PIXEL_W:0]   clr_q, clr_d;
  logic [PIXEL_W-1:0] pix_q, pix_d;
  logic [BIN_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic               tmr_load;
  logic               tmr_expire;

  hist_latency_timer #(.MEM_LAT(MEM_LAT)) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load_i   (tmr_load),
    .expire_o (tmr_expire)
  );

  // Handshake: start is a one-cycle request taken only in IDLE; done is a
  // one-cycle pulse in FIN. All strobes are one cycle wide and mutually exclusive.
  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    idx_d      = idx_q;
    clr_d      = clr_q;
    pix_d      = pix_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    in_rd_en   = 1'b0;
    in_rd_addr = '0;
    sc_rd_en   = 1'b0;
    sc_wr_en   = 1'b0;
    sc_addr    = '0;
    sc_wr_data = '0;
    done       = 1'b0;
    tmr_load   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d = num_pixels;
          idx_d = '0;
          clr_d = '0;
          sat_d = 1'b0;
          if (CLEAR_EN != 0)          state_d = S_CLEAR;
          else if (num_pixels == '0)  state_d = S_FIN;
          else                        state_d = S_IN_RD;
        end
      end
      S_CLEAR: begin
        sc_wr_en = 1'b1;
        sc_addr  = clr_q[PIXEL_W-1:0];
        clr_d    = clr_q + 1'b1;
        // The extra counter bit sets exactly when the last bin has been written.
        if (abort)                state_d = S_FIN;
        else if (clr_d[PIXEL_W])  state_d = (num_q == '0) ? S_FIN : S_IN_RD;
      end
      S_IN_RD: begin
        in_rd_en   = 1'b1;
        in_rd_addr = idx_q;
        tmr_load   = 1'b1;
        state_d    = abort ? S_FIN : S_IN_WAIT;
      end
      S_IN_WAIT: begin
        if (abort) begin
          state_d = S_FIN;
        end else if (tmr_expire) begin
          pix_d   = in_rd_data;
          state_d = S_SC_RD;
        end
      end
      S_SC_RD: begin
        sc_rd_en = 1'b1;
        sc_addr  = pix_q;
        tmr_load = 1'b1;
        state_d  = abort ? S_FIN : S_SC_WAIT;
      end
      S_SC_WAIT: begin
        if (abort) begin
          state_d = S_FIN;
        end else if (tmr_expire) begin
          cnt_d   = sc_rd_data;
          state_d = S_SC_WR;
        end
      end
      S_SC_WR: begin
        sc_wr_en = 1'b1;
        sc_addr  = pix_q;
        if (cnt_q == BIN_TOP) begin
          sc_wr_data = BIN_TOP;
          sat_d      = 1'b1;
        end else begin
          sc_wr_data = cnt_q + 1'b1;
        end
        idx_d   = idx_q + 1'b1;
        state_d = (abort || idx_d == num_q) ? S_FIN : S_IN_RD;
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      idx_q   <= '0;
      clr_q   <= '0;
      pix_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      clr_q   <= clr_d;
      pix_q   <= pix_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign busy      = (state_q != S_IDLE) && (state_q != S_FIN);
  assign saturated = sat_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_histogram_engine_ctrl.sv
// Directed bench for histogram_engine_ctrl: four configurations side by side,
// each with its own latency-accurate input and scratch memory models.
module tb_histogram_engine_ctrl;
  import histogram_pkg::*;

  localparam int NI = 4;

  function automatic int lat_of(input int g);
    return (g == 2) ? 1 : ((g == 3) ? 5 : 3);
  endfunction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n   [NI];
  logic        start   [NI];
  logic        abort_s [NI];
  logic [7:0]  num_px  [NI];
  logic        in_en   [NI];
  logic [7:0]  in_addr [NI];
  logic [3:0]  in_data [NI];
  logic        sc_ren  [NI];
  logic        sc_wen  [NI];
  logic [3:0]  sc_addr [NI];
  logic [15:0] sc_rdata[NI];
  logic [15:0] sc_wdata[NI];
  logic        busy    [NI];
  logic        done    [NI];
  logic        sat     [NI];
  hist_state_t st      [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int BW = (g == 1) ? 2 : 16;
    logic [BW-1:0] wd;
    histogram_engine_ctrl #(
      .PIXEL_W (4),
      .BIN_W   (BW),
      .ADDR_W  (8),
      .MEM_LAT ((g == 2) ? 1 : ((g == 3) ? 5 : 3)),
      .CLEAR_EN((g == 1) ? 0 : 1)
    ) u_dut (
      .clock      (clk),
      .reset_n    (rst_n[g]),
      .start      (start[g]),
      .abort      (abort_s[g]),
      .num_pixels (num_px[g]),
      .in_rd_en   (in_en[g]),
      .in_rd_addr (in_addr[g]),
      .in_rd_data (in_data[g]),
      .sc_rd_en   (sc_ren[g]),
      .sc_wr_en   (sc_wen[g]),
      .sc_addr    (sc_addr[g]),
      .sc_rd_data (sc_rdata[g][BW-1:0]),
      .sc_wr_data (wd),
      .busy       (busy[g]),
      .done       (done[g]),
      .saturated  (sat[g]),
      .dbg_state  (st[g])
    );
    assign sc_wdata[g] = 16'(wd);
  end

  // ---------------- memory models ----------------
  logic [3:0]  in_mem [NI][256];
  logic [15:0] sc_mem [NI][16];
  logic [3:0]  ipipe  [NI][8];
  logic [15:0] spipe  [NI][8];
  logic        pre_en;
  int          pre_g;
  logic [3:0]  pre_addr;
  logic [15:0] pre_data;

  // Data is valid only in the MEM_LAT-th cycle after the strobe; other slots carry poison.
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      for (int k = 7; k > 0; k--) begin
        ipipe[g][k] <= ipipe[g][k-1];
        spipe[g][k] <= spipe[g][k-1];
      end
      ipipe[g][0] <= in_en[g] ? in_mem[g][in_addr[g]] : 4'hF;
      spipe[g][0] <= sc_ren[g] ? sc_mem[g][sc_addr[g]] : 16'hDEAD;
      if (sc_wen[g]) sc_mem[g][sc_addr[g]] <= sc_wdata[g];
    end
    if (pre_en) sc_mem[pre_g][pre_addr] <= pre_data;
  end

  always_comb begin
    for (int g = 0; g < NI; g++) begin
      in_data[g]  = ipipe[g][lat_of(g)-1];
      sc_rdata[g] = spipe[g][lat_of(g)-1];
    end
  end

  // ---------------- monitor ----------------
  int          n_in[NI], n_srd[NI], n_swr[NI], n_done[NI];
  int          done_cyc[NI], in_cyc[NI], in_gap[NI], viol[NI];
  logic [15:0] last_wd[NI];

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (in_en[g]) begin
        n_in[g]++;
        in_gap[g] = cyc - in_cyc[g];
        in_cyc[g] = cyc;
      end
      if (sc_ren[g]) n_srd[g]++;
      if (sc_wen[g]) begin
        n_swr[g]++;
        last_wd[g] = sc_wdata[g];
      end
      if (done[g]) begin
        n_done[g]++;
        done_cyc[g] = cyc;
      end
      if (int'(in_en[g]) + int'(sc_ren[g]) + int'(sc_wen[g]) > 1) viol[g]++;
      if (!in_en[g] && in_addr[g] != 8'd0) viol[g]++;
      if (!sc_ren[g] && !sc_wen[g] && sc_addr[g] != 4'd0) viol[g]++;
      if (done[g] && busy[g]) viol[g]++;
    end
  end

  // ---------------- scoreboard / counters ----------------
  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_cycle(input int t);
    while (cyc < t) tick();
  endtask

  task automatic pulse_start(input int g, input logic [7:0] n, output int c);
    num_px[g] = n;
    start[g]  = 1'b1;
    c         = cyc;
    tick();
    start[g]  = 1'b0;
  endtask

  task automatic wait_done(input int g, input int n0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (n_done[g] != n0) ok = 1'b1;
    end
  endtask

  task automatic preload(input int g, input logic [3:0] a, input logic [15:0] d);
    pre_g    = g;
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    tick();
    pre_en   = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [36:0] obs;
    for (int g = 0; g < NI; g++) begin
      rst_n[g] = 1'b0; start[g] = 1'b0; abort_s[g] = 1'b0; num_px[g] = 8'd0;
    end
    pre_en = 1'b0; pre_g = 0; pre_addr = 4'd0; pre_data = 16'd0;
    tick(); tick();
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      obs = {in_en[g], sc_ren[g], sc_wen[g], busy[g], done[g], sat[g],
             in_addr[g], sc_addr[g], sc_wdata[g], st[g]};
      checks++;
      if (obs !== 37'd0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got %h expected 0", g, obs);
      end
    end
    tick();
    for (int g = 0; g < NI; g++) rst_n[g] = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int c, s_in, s_srd, s_swr, nd;
    bit ok;
    in_mem[0][0] = 4'd2; in_mem[0][1] = 4'd2; in_mem[0][2] = 4'd5;
    preload(0, 4'd2, 16'h0077);
    preload(0, 4'd5, 16'd9);
    preload(0, 4'd9, 16'd3);
    s_in = n_in[0]; s_srd = n_srd[0]; s_swr = n_swr[0]; nd = n_done[0];
    pulse_start(0, 8'd3, c);
    checks++;
    if (st[0] !== S_CLEAR) begin errors++; $display("FAIL basic_first_state: got %0d expected %0d", st[0], S_CLEAR); end
    wait_done(0, nd, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: got no done expected done"); end
    checks++;
    if (done_cyc[0] - c !== 44) begin errors++; $display("FAIL basic_latency: got %0d expected 44", done_cyc[0] - c); end
    checks++;
    if (n_swr[0] - s_swr !== 19) begin errors++; $display("FAIL basic_writes: got %0d expected 19", n_swr[0] - s_swr); end
    checks++;
    if (n_in[0] - s_in !== 3 || n_srd[0] - s_srd !== 3) begin
      errors++; $display("FAIL basic_reads: got %0d/%0d expected 3/3", n_in[0] - s_in, n_srd[0] - s_srd);
    end
    checks++;
    if (sc_mem[0][2] !== 16'd2) begin errors++; $display("FAIL basic_bin2: got %0d expected 2", sc_mem[0][2]); end
    checks++;
    if (sc_mem[0][5] !== 16'd1) begin errors++; $display("FAIL basic_bin5: got %0d expected 1", sc_mem[0][5]); end
    checks++;
    if (sc_mem[0][9] !== 16'd0) begin errors++; $display("FAIL basic_bin9_cleared: got %0d expected 0", sc_mem[0][9]); end
    checks++;
    if (in_gap[0] !== 9) begin errors++; $display("FAIL basic_period: got %0d expected 9", in_gap[0]); end
    checks++;
    if (sat[0] !== 1'b0 || busy[0] !== 1'b0) begin errors++; $display("FAIL basic_idle_flags: got sat=%b busy=%b expected 0/0", sat[0], busy[0]); end
  endtask

  task automatic test_zero_pixels();
    int c, s_all, nd;
    bit ok;
    s_all = n_in[1] + n_srd[1] + n_swr[1]; nd = n_done[1];
    pulse_start(1, 8'd0, c);
    wait_done(1, nd, 10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL zero_timeout: got no done expected done"); end
    checks++;
    if (done_cyc[1] - c !== 1) begin errors++; $display("FAIL zero_latency: got %0d expected 1", done_cyc[1] - c); end
    tick(); tick();
    checks++;
    if (n_in[1] + n_srd[1] + n_swr[1] - s_all !== 0) begin
      errors++; $display("FAIL zero_strobes: got %0d expected 0", n_in[1] + n_srd[1] + n_swr[1] - s_all);
    end
    checks++;
    if (n_done[1] - nd !== 1) begin errors++; $display("FAIL zero_done_pulses: got %0d expected 1", n_done[1] - nd); end
  endtask

  task automatic test_saturate();
    int c, nd;
    bit ok;
    preload(1, 4'd3, 16'd3);
    in_mem[1][0] = 4'd3;
    nd = n_done[1];
    pulse_start(1, 8'd1, c);
    wait_done(1, nd, 40, ok);
    checks++;
    if (!ok || done_cyc[1] - c !== 10) begin errors++; $display("FAIL sat_latency: got %0d expected 10", done_cyc[1] - c); end
    checks++;
    if (last_wd[1] !== 16'd3) begin errors++; $display("FAIL sat_wdata: got %0d expected 3", last_wd[1]); end
    checks++;
    if (sat[1] !== 1'b1) begin errors++; $display("FAIL sat_flag_set: got %b expected 1", sat[1]); end
    // Count 2 -> 3 reaches the maximum but is not itself a saturation.
    preload(1, 4'd2, 16'd2);
    in_mem[1][0] = 4'd2;
    nd = n_done[1];
    pulse_start(1, 8'd1, c);
    checks++;
    if (sat[1] !== 1'b0) begin errors++; $display("FAIL sat_flag_cleared: got %b expected 0", sat[1]); end
    wait_done(1, nd, 40, ok);
    checks++;
    if (!ok || last_wd[1] !== 16'd3) begin errors++; $display("FAIL sat_below_max_wdata: got %0d expected 3", last_wd[1]); end
    checks++;
    if (sat[1] !== 1'b0) begin errors++; $display("FAIL sat_below_max_flag: got %b expected 0", sat[1]); end
  endtask

  task automatic test_abort_start();
    int c, s_in, s_srd, s_swr, nd;
    bit ok;
    in_mem[0][0] = 4'd7; in_mem[0][1] = 4'd8; in_mem[0][2] = 4'd9;
    s_in = n_in[0]; s_srd = n_srd[0]; s_swr = n_swr[0]; nd = n_done[0];
    pulse_start(0, 8'd3, c);
    at_cycle(c + 23);
    checks++;
    if (st[0] !== S_SC_WAIT) begin errors++; $display("FAIL abort_state_scwait: got %0d expected %0d", st[0], S_SC_WAIT); end
    num_px[0] = 8'd1; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    at_cycle(c + 28);
    checks++;
    if (st[0] !== S_IN_WAIT) begin errors++; $display("FAIL abort_state_inwait: got %0d expected %0d", st[0], S_IN_WAIT); end
    abort_s[0] = 1'b1;
    tick();
    abort_s[0] = 1'b0;
    wait_done(0, nd, 60, ok);
    checks++;
    if (!ok || done_cyc[0] - c !== 29) begin errors++; $display("FAIL abort_latency: got %0d expected 29", done_cyc[0] - c); end
    checks++;
    if (n_in[0] - s_in !== 2 || n_srd[0] - s_srd !== 1 || n_swr[0] - s_swr !== 17) begin
      errors++;
      $display("FAIL abort_strobes: got in=%0d rd=%0d wr=%0d expected 2/1/17",
               n_in[0] - s_in, n_srd[0] - s_srd, n_swr[0] - s_swr);
    end
    checks++;
    if (sc_mem[0][7] !== 16'd1 || sc_mem[0][8] !== 16'd0) begin
      errors++; $display("FAIL abort_bins: got bin7=%0d bin8=%0d expected 1/0", sc_mem[0][7], sc_mem[0][8]);
    end
    checks++;
    if (n_done[0] - nd !== 1) begin errors++; $display("FAIL abort_done_pulses: got %0d expected 1", n_done[0] - nd); end
  endtask

  task automatic test_abort_idle();
    int c, nd;
    bit ok;
    nd = n_done[0];
    abort_s[0] = 1'b1;
    tick();
    abort_s[0] = 1'b0;
    checks++;
    if (st[0] !== S_IDLE || n_done[0] !== nd) begin errors++; $display("FAIL abort_in_idle: got state %0d expected %0d", st[0], S_IDLE); end
    num_px[0] = 8'd0; start[0] = 1'b1; abort_s[0] = 1'b1; c = cyc;
    tick();
    start[0] = 1'b0; abort_s[0] = 1'b0;
    checks++;
    if (st[0] !== S_CLEAR) begin errors++; $display("FAIL start_beats_abort: got %0d expected %0d", st[0], S_CLEAR); end
    wait_done(0, nd, 40, ok);
    checks++;
    if (!ok || done_cyc[0] - c !== 17) begin errors++; $display("FAIL clear_only_latency: got %0d expected 17", done_cyc[0] - c); end
  endtask

  task automatic test_reset_mid();
    int c, nd, s_swr;
    bit ok;
    logic [36:0] obs;
    in_mem[0][0] = 4'd4;
    nd = n_done[0];
    pulse_start(0, 8'd1, c);
    at_cycle(c + 5);
    checks++;
    if (st[0] !== S_CLEAR) begin errors++; $display("FAIL rst_mid_state: got %0d expected %0d", st[0], S_CLEAR); end
    rst_n[0] = 1'b0;
    tick();
    rst_n[0] = 1'b1;
    @(negedge clk);
    obs = {in_en[0], sc_ren[0], sc_wen[0], busy[0], done[0], sat[0],
           in_addr[0], sc_addr[0], sc_wdata[0], st[0]};
    checks++;
    if (obs !== 37'd0) begin errors++; $display("FAIL rst_mid_outputs: got %h expected 0", obs); end
    tick(); tick(); tick();
    checks++;
    if (n_done[0] !== nd || st[0] !== S_IDLE) begin errors++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", n_done[0] - nd); end
    s_swr = n_swr[0];
    pulse_start(0, 8'd1, c);
    wait_done(0, nd, 60, ok);
    checks++;
    if (!ok || done_cyc[0] - c !== 26) begin errors++; $display("FAIL rst_fresh_latency: got %0d expected 26", done_cyc[0] - c); end
    checks++;
    if (sc_mem[0][4] !== 16'd1 || n_swr[0] - s_swr !== 17) begin
      errors++; $display("FAIL rst_fresh_result: got bin4=%0d writes=%0d expected 1/17", sc_mem[0][4], n_swr[0] - s_swr);
    end
  endtask

  task automatic test_sweep(input int g);
    int c, nd, lat, n;
    bit ok;
    logic [15:0] model[16];
    logic [15:0] e;
    lat = lat_of(g);
    n   = 20;
    for (int b = 0; b < 16; b++) model[b] = 16'd0;
    for (int i = 0; i < n; i++) begin
      in_mem[g][i] = 4'($urandom_range(0, 15));
      model[in_mem[g][i]] = model[in_mem[g][i]] + 16'd1;
    end
    for (int b = 0; b < 16; b++) exp_q.push_back(model[b]);
    nd = n_done[g];
    pulse_start(g, 8'(n), c);
    wait_done(g, nd, 400, ok);
    checks++;
    if (!ok || done_cyc[g] - c !== 16 + n * (2 * lat + 3) + 1) begin
      errors++; $display("FAIL sweep%0d_latency: got %0d expected %0d", g, done_cyc[g] - c, 16 + n * (2 * lat + 3) + 1);
    end
    checks++;
    if (in_gap[g] !== 2 * lat + 3) begin errors++; $display("FAIL sweep%0d_period: got %0d expected %0d", g, in_gap[g], 2 * lat + 3); end
    for (int b = 0; b < 16; b++) begin
      e = exp_q.pop_front();
      checks++;
      if (sc_mem[g][b] !== e) begin errors++; $display("FAIL sweep%0d_bin%0d: got %0d expected %0d", g, b, sc_mem[g][b], e); end
    end
  endtask

  task automatic test_invariants();
    for (int g = 0; g < NI; g++) begin
      checks++;
      if (viol[g] !== 0) begin errors++; $display("FAIL strobe_rules[%0d]: got %0d violations expected 0", g, viol[g]); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_zero_pixels();
    test_saturate();
    test_abort_start();
    test_abort_idle();
    test_reset_mid();
    test_sweep(2);
    test_sweep(3);
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
